keypad_number_entry: RTL and testbench

- Input-side counterpart of the four-digit seven-segment display driver. The display splits a binary value into decimal digits; this block builds a binary value from decimal digits.
- Scans a 4x4 matrix keypad, debounces it and emits one strobe per key press.
- Accumulates decimal digits into an 8-bit value and presents it on Enter.
- Its output feeds the `displayed` input of the display driver and the systolic-array operand registers.

---
 rtl/keypad_number_entry.sv | 186 ++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_number_entry.sv
// 4x4 matrix keypad scanner with debounce and decimal entry.
// Digits build an 8-bit value; '#' commits it, '*' clears it.
module keypad_number_entry #(
  parameter int SCAN_DIV       = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [7:0] entered_value,
  output logic       value_valid,
  output logic       overflow
);

  localparam int CW = SCAN_DIV + 2;
  localparam logic [7:0] DB = 8'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    col;
  logic          dwell_last;
  logic          scan_done;
  logic [15:0]   raw;
  logic [15:0]   raw_next;
  logic [15:0]   prev_snap;
  logic [15:0]   db_snap;
  logic [7:0]    run_cnt;
  logic [7:0]    cnt_next;
  logic          same;
  logic          db_fire;
  logic          db_upd;
  logic [1:0]    state;
  logic [7:0]    acc;
  logic [11:0]   acc_next;
  logic [3:0]    key_idx;
  logic [3:0]    code;
  logic          none_key;
  logic          one_key;
  logic          press;

  assign col        = scan_cnt[CW-1 -: 2];
  assign dwell_last = &scan_cnt[SCAN_DIV-1:0];
  assign scan_done  = &scan_cnt;
  assign col_out    = ~(4'b0001 << col);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hf;
      row_sync <= 4'hf;
      scan_cnt <= '0;
      raw      <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      scan_cnt <= scan_cnt + CW'(1);
      raw      <= raw_next;
    end
  end

  // Rows are sampled at the end of each dwell; bit index = row*4+col.
  always_comb begin
    raw_next = raw;
    if (dwell_last) begin
      for (int r = 0; r < 4; r++) begin
        raw_next[{2'(r), col}] = ~row_sync[r];
      end
    end
  end

  assign same     = (raw_next == prev_snap);
  assign cnt_next = !same ? 8'd1 :
                    (run_cnt >= DB) ? DB : run_cnt + 8'd1;
  assign db_fire  = scan_done && (cnt_next == DB) &&
                    !(same && run_cnt == DB);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      prev_snap <= '0;
      run_cnt   <= '0;
      db_snap   <= '0;
      db_upd    <= 1'b0;
    end else begin
      db_upd <= db_fire;
      if (scan_done) begin
        prev_snap <= raw_next;
        run_cnt   <= cnt_next;
      end
      if (db_fire) db_snap <= raw_next;
    end
  end

  assign none_key = (db_snap == 16'd0);
  assign one_key  = !none_key &&
                    ((db_snap & (db_snap - 16'd1)) == 16'd0);

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (db_snap[i]) key_idx = 4'(i);
    end
  end

  always_comb begin
    code = 4'd0;
    unique case (key_idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
  end

  assign acc_next = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) +
                    {8'd0, code};
  assign press    = db_upd && (state == IDLE) && one_key;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (db_upd) begin
      unique case (state)
        IDLE:    state <= none_key ? IDLE :
                          one_key  ? PRESSED : BLOCKED;
        PRESSED: state <= none_key ? IDLE : PRESSED;
        BLOCKED: state <= none_key ? IDLE : BLOCKED;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      key_code      <= 4'd0;
      key_strobe    <= 1'b0;
      entered_value <= 8'd0;
      value_valid   <= 1'b0;
      overflow      <= 1'b0;
      acc           <= 8'd0;
    end else begin
      key_strobe  <= 1'b0;
      value_valid <= 1'b0;
      if (press) begin
        key_code   <= code;
        key_strobe <= 1'b1;
        unique case (1'b1)
          (code <= 4'd9): begin
            if (acc_next <= 12'd255) acc <= acc_next[7:0];
            else overflow <= 1'b1;
          end
          (code == 4'd14): begin
            acc      <= 8'd0;
            overflow <= 1'b0;
          end
          (code == 4'd15): begin
            entered_value <= acc;
            value_valid   <= 1'b1;
            acc           <= 8'd0;
            overflow      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Scoreboard bench: keypad model drives rows from col_out,
// monitor pops expected codes and committed values.
`timescale 1ns/1ps
module tb_keypad_number_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [7:0] entered_value;
  logic       value_valid;
  logic       overflow;

  logic [15:0] keys = 16'd0;
  logic [3:0]  exp_keys[$];
  logic [7:0]  exp_vals[$];
  int          errors = 0;
  int          checks = 0;
  logic        last_strobe = 1'b0;
  logic        last_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_number_entry #(.SCAN_DIV(2), .DEBOUNCE_SCANS(4)) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .row_in       (row_in),
    .col_out      (col_out),
    .key_code     (key_code),
    .key_strobe   (key_strobe),
    .entered_value(entered_value),
    .value_valid  (value_valid),
    .overflow     (overflow)
  );

  always_comb begin
    row_in = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (key_strobe) begin
        check("strobe_width", int'(last_strobe), 0);
        if (exp_keys.size() == 0) begin
          check("unexpected_strobe", int'(key_code), -1);
        end else begin
          check("key_code", int'(key_code), int'(exp_keys.pop_front()));
        end
      end
      if (value_valid) begin
        check("valid_width", int'(last_valid), 0);
        if (exp_vals.size() == 0) begin
          check("unexpected_valid", int'(entered_value), -1);
        end else begin
          check("entered_value", int'(entered_value),
                int'(exp_vals.pop_front()));
        end
      end
    end
    last_strobe = key_strobe;
    last_valid  = value_valid;
  end

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic tap(input int idx, input logic [3:0] code);
    exp_keys.push_back(code);
    keys = 16'd1 << idx;
    scans(8);
    keys = 16'd0;
    scans(8);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_value", int'(entered_value), 0);
    check("rst_col", int'(col_out), 14);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_col_out", int'(col_out), 14);
    check("rst_key_code", int'(key_code), 0);
    check("rst_strobe", int'(key_strobe), 0);
    check("rst_value", int'(entered_value), 0);
    check("rst_valid", int'(value_valid), 0);
    check("rst_overflow", int'(overflow), 0);

    // 1: column rotation with no keys
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("col_rotate", int'(col_out), int'(~(4'b0001 << ((k / 4) % 4)) & 4'hf));
      @(negedge clk);
    end
    scans(6);
    check("idle_value", int'(entered_value), 0);
    check("idle_overflow", int'(overflow), 0);

    // 2: 1,2,3,# -> 123
    tap(0, 4'd1);
    tap(1, 4'd2);
    tap(2, 4'd3);
    exp_vals.push_back(8'd123);
    tap(14, 4'd15);
    check("after_123_overflow", int'(overflow), 0);

    // 3: 2,5,6 overflows, # commits 25; then 255
    tap(1, 4'd2);
    tap(5, 4'd5);
    tap(6, 4'd6);
    check("ovf_set", int'(overflow), 1);
    exp_vals.push_back(8'd25);
    tap(14, 4'd15);
    check("ovf_clear", int'(overflow), 0);
    tap(1, 4'd2);
    tap(5, 4'd5);
    tap(5, 4'd5);
    exp_vals.push_back(8'd255);
    tap(14, 4'd15);
    check("max_overflow", int'(overflow), 0);

    // 4: bouncing '5' then long hold -> one strobe
    exp_keys.push_back(4'd5);
    keys = 16'd1 << 5;
    scans(1);
    keys = 16'd0;
    scans(1);
    keys = 16'd1 << 5;
    scans(60);
    keys = 16'd0;
    scans(8);
    check("hold_pending", exp_keys.size(), 0);

    // 5: double press ignored, then 7; acc 57, 4 overflows
    keys = (16'd1 << 0) | (16'd1 << 5);
    scans(8);
    keys = 16'd0;
    scans(8);
    tap(8, 4'd7);
    tap(4, 4'd4);
    check("ovf_574", int'(overflow), 1);
    tap(12, 4'd14);
    check("star_clear_ovf", int'(overflow), 0);
    tap(10, 4'd9);
    exp_vals.push_back(8'd9);
    tap(14, 4'd15);

    // 6: reset mid-entry discards 4,2
    tap(4, 4'd4);
    tap(1, 4'd2);
    pulse_reset();
    tap(10, 4'd9);
    exp_vals.push_back(8'd9);
    tap(14, 4'd15);
    tap(7, 4'd11);
    check("b_value_kept", int'(entered_value), 9);
    check("b_code", int'(key_code), 11);

    scans(4);
    check("keys_drained", exp_keys.size(), 0);
    check("vals_drained", exp_vals.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
